// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage feeding the ALU operation stream.
// Decoded ops pass through a main+skid elastic buffer with valid/ready on both sides.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_alu_control,
    output logic [XLEN-1:0] out_src_a,
    output logic [XLEN-1:0] out_src_b,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_is_branch,
    output logic [2:0]      out_branch_funct3,
    output logic            out_illegal
);

    typedef struct packed {
        logic [3:0]      alu_control;
        logic [XLEN-1:0] src_a;
        logic [XLEN-1:0] src_b;
        logic [4:0]      rd;
        logic            reg_write;
        logic            is_branch;
        logic [2:0]      br_funct3;
        logic            illegal;
    } op_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;
    logic            is_op;
    logic            is_opi;
    logic            is_load;
    logic            is_store;
    logic            is_br;
    logic            is_lui;
    logic            is_auipc;
    logic            is_jump;
    op_t             dec;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign imm_i    = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s    = {{(XLEN-12){in_instr[31]}}, in_instr[31:25],
                       in_instr[11:7]};
    assign imm_u    = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
    assign shamt    = {{(XLEN-5){1'b0}}, in_instr[24:20]};

    assign is_op    = (opcode == 7'b0110011);
    assign is_opi   = (opcode == 7'b0010011);
    assign is_load  = (opcode == 7'b0000011);
    assign is_store = (opcode == 7'b0100011);
    assign is_br    = (opcode == 7'b1100011);
    assign is_lui   = (opcode == 7'b0110111);
    assign is_auipc = (opcode == 7'b0010111);
    assign is_jump  = (opcode == 7'b1101111) || (opcode == 7'b1100111);

    always_comb begin
        dec             = '0;
        dec.rd          = in_instr[11:7];
        dec.alu_control = ALU_ADD;
        unique case (1'b1)
            is_op: begin
                dec.alu_control = {in_instr[30], funct3};
                dec.src_a       = in_rs1_data;
                dec.src_b       = in_rs2_data;
                dec.reg_write   = 1'b1;
            end
            is_opi: begin
                dec.alu_control = {(funct3 == 3'b101) & in_instr[30], funct3};
                dec.src_a       = in_rs1_data;
                dec.src_b       = (funct3[1:0] == 2'b01) ? shamt : imm_i;
                dec.reg_write   = 1'b1;
            end
            is_load: begin
                dec.src_a     = in_rs1_data;
                dec.src_b     = imm_i;
                dec.reg_write = 1'b1;
            end
            is_store: begin
                dec.src_a = in_rs1_data;
                dec.src_b = imm_s;
            end
            is_br: begin
                // funct3 010/011 are not branch encodings in RV32I
                if (funct3[2:1] == 2'b01) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.alu_control = !funct3[2] ? ALU_SUB :
                                      (funct3[1] ? ALU_SLTU : ALU_SLT);
                    dec.src_a       = in_rs1_data;
                    dec.src_b       = in_rs2_data;
                    dec.is_branch   = 1'b1;
                    dec.br_funct3   = funct3;
                end
            end
            is_lui: begin
                dec.src_b     = imm_u;
                dec.reg_write = 1'b1;
            end
            is_auipc: begin
                dec.src_a     = in_pc;
                dec.src_b     = imm_u;
                dec.reg_write = 1'b1;
            end
            is_jump: begin
                dec.src_a     = in_pc;
                dec.src_b     = XLEN'(4);
                dec.reg_write = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        if (dec.rd == 5'd0) dec.reg_write = 1'b0;
    end

    op_t  main_q, main_d;
    op_t  skid_q, skid_d;
    logic main_vld_q, main_vld_d;
    logic skid_vld_q, skid_vld_d;
    logic in_fire;
    logic out_fire;

    assign in_ready = !skid_vld_q;
    assign in_fire  = in_valid && in_ready && !flush;
    assign out_fire = main_vld_q && out_ready;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || out_fire) begin
            // skid is only occupied while in_ready is low, so no new op here
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = in_fire;
                if (in_fire) main_d = dec;
            end
        end else if (in_fire) begin
            skid_d     = dec;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign out_valid         = main_vld_q;
    assign out_alu_control   = main_q.alu_control;
    assign out_src_a         = main_q.src_a;
    assign out_src_b         = main_q.src_b;
    assign out_rd            = main_q.rd;
    assign out_reg_write     = main_q.reg_write;
    assign out_is_branch     = main_q.is_branch;
    assign out_branch_funct3 = main_q.br_funct3;
    assign out_illegal       = main_q.illegal;

endmodule
